// File: rtl/rr_req_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// A grant is held until done, the owner's request drops, or MAX_HOLD cycles pass.
module rr_req_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);
  localparam logic [1:0]       PTR_RST  = 2'(PTR_INIT);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;
  logic       release_now;
  logic       hold_expired;

  // Rotating scan: ptr has highest priority, 2-bit index wraps 3 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign hold_expired = (hold_cnt_q == HOLD_MAX);
  assign release_now  = done || !req[owner_q] || hold_expired;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (win_found) begin
          owner_d    = win_idx;
          grant_d    = 4'(4'b0001 << win_idx);
          hold_cnt_d = HOLD_ONE;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Timeout only flags a release that nothing else would have caused.
          timeout_d = hold_expired && !done && req[owner_q];
          grant_d   = 4'b0000;
          ptr_d     = owner_q + 2'd1;
          state_d   = IDLE;
        end else if (!hold_expired) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_RST;
      owner_q       <= 2'd0;
      grant_q       <= 4'b0000;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter_4.sv
// Directed and randomized bench for rr_req_arbiter_4 against a behavioural
// owner/pointer model; inputs change 1 time unit after each rising edge.
module tb_rr_req_arbiter_4;

  localparam int MAX_HOLD = 16;
  localparam int PTR_INIT = 0;
  localparam int LIMIT    = 3 * (MAX_HOLD + 1);

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] req  = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Model: owner -1 means nobody holds the grant.
  int   m_owner;
  int   m_ptr;
  int   m_held;
  bit   m_timeout;
  int   wait_cnt[4];
  int   max_wait[4];
  logic [3:0] prev_req;

  rr_req_arbiter_4 #(
    .MAX_HOLD(MAX_HOLD),
    .PTR_INIT(PTR_INIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = PTR_INIT;
    m_held    = 0;
    m_timeout = 0;
    prev_req  = 4'b0000;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // Called before an edge with the inputs that edge will sample.
  task automatic model_step();
    bit rel;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (req[i] && prev_req[i] && !grant[i]) wait_cnt[i]++;
      else if (!req[i] || grant[i]) wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
    end
    prev_req = req;
    if (m_owner < 0) begin
      m_timeout = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_held  = 1;
        end
      end
    end else begin
      rel = done || !req[m_owner] || (m_held == MAX_HOLD);
      if (rel) begin
        m_timeout = (m_held == MAX_HOLD) && !done && req[m_owner];
        m_ptr     = (m_owner + 1) % 4;
        m_owner   = -1;
      end else begin
        m_held++;
        m_timeout = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("grant", grant, exp_grant());
    check("grant_valid", grant_valid, exp_grant() != 4'b0000);
    check("timeout", timeout, m_timeout);
    check("onehot0", $onehot0(grant), 1);
    check("valid_eq_or", grant_valid, |grant);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  logic [3:0] seq2 [8];

  initial begin
    for (int i = 0; i < 4; i++) max_wait[i] = 0;
    seq2[0] = 4'b0000; seq2[1] = 4'b0010; seq2[2] = 4'b0000; seq2[3] = 4'b0100;
    seq2[4] = 4'b0000; seq2[5] = 4'b1000; seq2[6] = 4'b0000; seq2[7] = 4'b0001;

    // Reset state, then async reset in the middle of a grant.
    do_reset();
    check("rst_grant", grant, 4'b0000);
    check("rst_timeout", timeout, 0);
    req = 4'b0100;
    cycle();
    check("t1_pre_grant", grant, 4'b0100);
    rst = 1'b1;
    #2;
    check("t1_async_grant", grant, 4'b0000);
    check("t1_async_valid", grant_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    cycle();
    check("t1_first_grant", grant, 4'b0001);

    // Full rotation with done pulsed during each grant.
    for (int i = 0; i < 8; i++) begin
      done = (i % 2 == 0);
      cycle();
      check("t2_seq", grant, seq2[i]);
    end
    done = 1'b0;

    // Lone requester runs into the hold limit.
    do_reset();
    req = 4'b0010;
    cycle();
    check("t3_grant", grant, 4'b0010);
    for (int i = 1; i < MAX_HOLD; i++) begin
      cycle();
      check("t3_hold", grant, 4'b0010);
      check("t3_no_to", timeout, 0);
    end
    cycle();
    check("t3_release", grant, 4'b0000);
    check("t3_timeout", timeout, 1);
    cycle();
    check("t3_regrant", grant, 4'b0010);
    check("t3_to_clear", timeout, 0);

    // Owner 3 drops its request; pointer wraps to 0.
    do_reset();
    req = 4'b1000;
    cycle();
    check("t4_grant3", grant, 4'b1000);
    req = 4'b0001;
    cycle();
    check("t4_release", grant, 4'b0000);
    check("t4_no_to", timeout, 0);
    req = 4'b1001;
    cycle();
    check("t4_wrap", grant, 4'b0001);

    // done coincides with the hold limit: normal release.
    do_reset();
    req = 4'b0100;
    cycle();
    for (int i = 1; i < MAX_HOLD; i++) cycle();
    check("t5_held", grant, 4'b0100);
    done = 1'b1;
    cycle();
    done = 1'b0;
    check("t5_release", grant, 4'b0000);
    check("t5_no_to", timeout, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4; i++) max_wait[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
      done = ($urandom_range(0, 9) == 0);
      cycle();
    end
    for (int i = 0; i < 4; i++)
      check("fairness_over_limit", max_wait[i] > LIMIT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
